// File: rtl/iob_plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// iob_plic_claim_ctrl
//
// Hardware servicing of one PLIC target interrupt line. When irq is seen in
// IDLE (and enable is high) the block reads the target's claim register over
// IOb, hands the claimed source ID to a consumer with a valid/ready handshake,
// waits for the consumer's done pulse and then writes the same ID back to the
// claim/complete register. Claims returning 0 or an ID above SOURCES are
// spurious: they are counted (saturating) and dropped without a complete.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable          allows a new claim to start (never aborts one in flight)
//   irq             PLIC target interrupt (meip)
//   m_valid, m_address, m_wdata, m_wstrb
//                   IOb request (registered; wstrb all-zero means read)
//   m_rdata, m_ready
//                   IOb response
//   id_valid, id, id_ready
//                   claimed source ID towards the consumer
//   done            single-cycle pulse, consumer finished handling the ID
//   busy            registered, high whenever the FSM is not IDLE
//   spurious_cnt    saturating count of spurious claims
// ---------------------------------------------------------------------------
module iob_plic_claim_ctrl #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter int                ID_W       = 4,
  parameter int                SOURCES    = 8,
  parameter logic [ADDR_W-1:0] CLAIM_ADDR = 16'h0004
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  irq,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready,
  output logic                  id_valid,
  output logic [ID_W-1:0]       id,
  input  logic                  id_ready,
  input  logic                  done,
  output logic                  busy,
  output logic [7:0]            spurious_cnt
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLAIM    = 3'd1,
    PRESENT  = 3'd2,
    SERVICE  = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                rd_hs;
  logic                spurious;
  logic                m_valid_nxt;
  logic [ADDR_W-1:0]   m_address_nxt;
  logic [DATA_W-1:0]   m_wdata_nxt;
  logic [STRB_W-1:0]   m_wstrb_nxt;
  logic                id_valid_nxt;
  logic [ID_W-1:0]     id_nxt;
  logic [7:0]          spurious_cnt_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The claim value is judged on the full bus word so that a large garbage
  // value cannot alias into a valid ID after truncation to ID_W bits.
  assign rd_hs    = (state == CLAIM) && m_valid && m_ready;
  assign spurious = (m_rdata == '0) || (m_rdata > DATA_W'(SOURCES));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (irq && enable)         state_nxt = CLAIM;
      CLAIM:    if (rd_hs)                 state_nxt = spurious ? IDLE : PRESENT;
      PRESENT:  if (id_valid && id_ready)  state_nxt = SERVICE;
      SERVICE:  if (done)                  state_nxt = COMPLETE;
      COMPLETE: if (m_valid && m_ready)    state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // All outputs are registered copies of what the next state requires, so
  // they hold steady for as long as the FSM waits in a state.
  always_comb begin
    m_valid_nxt      = 1'b0;
    m_address_nxt    = '0;
    m_wdata_nxt      = '0;
    m_wstrb_nxt      = '0;
    id_valid_nxt     = 1'b0;
    id_nxt           = id;
    spurious_cnt_nxt = spurious_cnt;

    if (rd_hs) begin
      if (spurious) spurious_cnt_nxt = sat_inc8(spurious_cnt);
      else          id_nxt           = m_rdata[ID_W-1:0];
    end

    case (state_nxt)
      CLAIM: begin
        m_valid_nxt   = 1'b1;
        m_address_nxt = CLAIM_ADDR;
      end
      PRESENT: begin
        id_valid_nxt  = 1'b1;
      end
      COMPLETE: begin
        m_valid_nxt   = 1'b1;
        m_address_nxt = CLAIM_ADDR;
        m_wstrb_nxt   = '1;
        m_wdata_nxt   = DATA_W'(id_nxt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      m_valid      <= 1'b0;
      m_address    <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
      id_valid     <= 1'b0;
      id           <= '0;
      busy         <= 1'b0;
      spurious_cnt <= '0;
    end else begin
      state        <= state_nxt;
      m_valid      <= m_valid_nxt;
      m_address    <= m_address_nxt;
      m_wdata      <= m_wdata_nxt;
      m_wstrb      <= m_wstrb_nxt;
      id_valid     <= id_valid_nxt;
      id           <= id_nxt;
      busy         <= (state_nxt != IDLE);
      spurious_cnt <= spurious_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_iob_plic_claim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_plic_claim_ctrl
//
// Transaction-level bench: each claim is described by its read value and the
// delays of slave, consumer and done. Expected bus requests, ID hand-off and
// the saturating spurious count are derived from those parameters.
// ---------------------------------------------------------------------------
module tb_iob_plic_claim_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        irq;
  logic        m_valid;
  logic [15:0] m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        id_valid;
  logic [3:0]  id;
  logic        id_ready;
  logic        done;
  logic        busy;
  logic [7:0]  spurious_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_spur = 0;

  iob_plic_claim_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .irq          (irq),
    .m_valid      (m_valid),
    .m_address    (m_address),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_rdata      (m_rdata),
    .m_ready      (m_ready),
    .id_valid     (id_valid),
    .id           (id),
    .id_ready     (id_ready),
    .done         (done),
    .busy         (busy),
    .spurious_cnt (spurious_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [52:0] req_vec();
    return {m_valid, m_address, m_wstrb, m_wdata};
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_bus"},  req_vec(),    53'd0);
    chk({tag, "_idv"},  id_valid,     1'b0);
    chk({tag, "_id"},   id,           4'd0);
    chk({tag, "_busy"}, busy,         1'b0);
    chk({tag, "_spur"}, spurious_cnt, 8'd0);
  endtask

  // One complete irq-initiated sequence, starting and ending in IDLE.
  task automatic run_claim(input logic [31:0] rdata, input int rdly, input int iddly,
                           input int ddly, input int wdly, input bit done_early,
                           input bit drop_en);
    logic [3:0]  exp_id;
    logic [52:0] rd_req;
    logic [52:0] wr_req;
    bit          spur;
    spur   = (rdata == 32'd0) || (rdata > 32'd8);
    exp_id = rdata[3:0];
    rd_req = {1'b1, 16'h0004, 4'h0, 32'h0};
    wr_req = {1'b1, 16'h0004, 4'hF, 28'h0, exp_id};

    enable = 1'b1;
    irq    = 1'b1;
    tick();
    irq = 1'b0;
    chk("claim_busy", busy, 1'b1);
    for (int i = 0; i < rdly; i++) begin
      chk("rd_req_hold", req_vec(), rd_req);
      tick();
    end
    chk("rd_req", req_vec(), rd_req);
    m_ready = 1'b1;
    m_rdata = rdata;
    tick();
    m_ready = 1'b0;
    m_rdata = $urandom;

    if (spur) begin
      if (exp_spur < 255) exp_spur++;
      chk("spur_idv",  id_valid,     1'b0);
      chk("spur_bus",  req_vec(),    53'd0);
      chk("spur_busy", busy,         1'b0);
      chk("spur_cnt",  spurious_cnt, exp_spur[7:0]);
      return;
    end

    for (int i = 0; i < iddly; i++) begin
      chk("present_idv", id_valid, 1'b1);
      chk("present_id",  id,       exp_id);
      chk("present_bus", req_vec(), 53'd0);
      done = done_early && (i == iddly / 2);
      tick();
      done = 1'b0;
    end
    chk("present_idv", id_valid, 1'b1);
    chk("present_id",  id,       exp_id);
    id_ready = 1'b1;
    done     = done_early;
    tick();
    id_ready = 1'b0;
    done     = 1'b0;
    chk("svc_idv", id_valid, 1'b0);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < ddly; i++) begin
      chk("svc_bus",  req_vec(), 53'd0);
      chk("svc_busy", busy,      1'b1);
      tick();
    end
    chk("svc_bus", req_vec(), 53'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < wdly; i++) begin
      chk("wr_req_hold", req_vec(), wr_req);
      tick();
    end
    chk("wr_req", req_vec(), wr_req);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("end_bus",  req_vec(),    53'd0);
    chk("end_busy", busy,         1'b0);
    chk("end_spur", spurious_cnt, exp_spur[7:0]);
    enable = 1'b1;
  endtask

  initial begin
    logic [31:0] rv;
    rst      = 1'b1;
    enable   = 1'b1;
    irq      = 1'b0;
    m_rdata  = 32'd0;
    m_ready  = 1'b0;
    id_ready = 1'b0;
    done     = 1'b0;
    repeat (3) tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    // basic claim/complete
    run_claim(32'd5, 0, 0, 3, 0, 1'b0, 1'b0);
    // spurious claims: zero and above SOURCES
    run_claim(32'd0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_claim(32'd9, 0, 0, 0, 0, 1'b0, 1'b0);
    // backpressure
    run_claim(32'd7, 4, 0, 1, 4, 1'b0, 1'b0);
    run_claim(32'd3, 0, 6, 2, 0, 1'b1, 1'b0);
    // dropping enable during SERVICE
    run_claim(32'd4, 1, 1, 3, 2, 1'b0, 1'b1);
    // boundary IDs
    run_claim(32'd8, 0, 0, 0, 0, 1'b1, 1'b0);
    run_claim(32'd1, 0, 0, 0, 0, 1'b0, 1'b0);

    // enable gating with irq held high
    enable = 1'b0;
    irq    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_busy", busy,      1'b0);
      chk("gate_bus",  req_vec(), 53'd0);
    end
    irq    = 1'b0;
    enable = 1'b1;
    tick();

    // randomized claims
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 32'd0;
        1:       rv = $urandom | 32'h0000_0100;
        default: rv = 32'($urandom_range(1, 8));
      endcase
      run_claim(rv, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // saturation of the spurious counter
    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(9, 1000));
      run_claim(rv, 0, 0, 0, 0, 1'b0, 1'b0);
    end
    chk("spur_saturated", spurious_cnt, 8'd255);

    // reset during CLAIM, irq kept high afterwards
    irq = 1'b1;
    tick();
    chk("pre_rst_claim", m_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_spur = 0;
    chk_reset_state("rst_claim");
    tick();
    irq = 1'b0;
    chk("fresh_read", req_vec(), {1'b1, 16'h0004, 4'h0, 32'h0});
    m_ready = 1'b1;
    m_rdata = 32'd0;
    tick();
    m_ready = 1'b0;
    exp_spur = 1;
    chk("after_rst_spur", spurious_cnt, 8'd1);

    // reset during COMPLETE
    irq = 1'b1;
    tick();
    irq     = 1'b0;
    m_ready = 1'b1;
    m_rdata = 32'd2;
    tick();
    m_ready  = 1'b0;
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    done     = 1'b1;
    tick();
    done = 1'b0;
    chk("pre_rst_wr", req_vec(), {1'b1, 16'h0004, 4'hF, 32'd2});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_spur = 0;
    chk_reset_state("rst_complete");
    tick();
    chk("stay_idle", busy, 1'b0);

    // normal operation after reset
    run_claim(32'd6, 2, 2, 2, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
